// File: rtl/dmem_responder.sv
// Data-memory responder for the LSU load/store port.
// Services one request at a time after a fixed wait latency.
module dmem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic [31:0]       mem [DEPTH_WORDS];

    logic [ADDR_W-3:0] widx;
    logic [IDX_W-1:0]  idx;
    logic              err;

    assign widx = addr[ADDR_W-1:2];
    assign idx  = addr[IDX_W+1:2];
    assign err  = (addr[1:0] != 2'b00) ||
                  (widx >= (ADDR_W-2)'(DEPTH_WORDS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
            wr        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            be        <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr        <= req_write;
                        addr      <= req_addr;
                        wdata     <= req_wdata;
                        be        <= req_be;
                        cnt       <= 4'(LATENCY);
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // Counter is spent one edge before the access fires.
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= '0;
                        if (!err) begin
                            if (wr) begin
                                for (int b = 0; b < 4; b++) begin
                                    if (be[b]) begin
                                        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                                    end
                                end
                            end else begin
                                rsp_rdata <= mem[idx];
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
